// File: rtl/cpu_pkg.sv
// Shared CPU definitions: reset vector, NOP encoding, opcodes and the fetch FSM encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_SLTI  = 6'b000001;
  localparam logic [5:0] OP_LW    = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b000111;
  localparam logic [5:0] OP_BEQ   = 6'b000110;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding an acked instruction and its pc+4 while decode is stalled.
// Clear wins over load so a redirect always discards whatever would be captured.
module fetch_skid
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        clear_i,
  input  logic [31:0] data_i,
  input  logic [31:0] pc4_i,
  output logic [31:0] data_o,
  output logic [31:0] pc4_o,
  output logic        valid_o
);

  logic [31:0] data_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      pc4_q   <= pc4_i;
      valid_q <= 1'b1;
    end
  end

  assign data_o  = data_q;
  assign pc4_o   = pc4_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: pc register, single-outstanding imem request FSM and IF/ID register.
// A word acked under stall parks in the skid buffer; branch redirect beats stall and ack.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;

  logic         skid_load, skid_clear, skid_valid;
  logic [31:0]  skid_data, skid_pc4;
  logic [31:0]  pc_plus4;
  logic         accept;

  assign pc_plus4 = pc_q + 32'd4;
  assign accept   = (state_q == S_REQ) && imem_ack;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_REQ;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (branch_taken) begin
      state_d = S_REQ;
    end else begin
      case (state_q)
        S_REQ:   if (imem_ack && stall) state_d = S_HOLD;
        S_HOLD:  if (!stall) state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  // Gated by rst_n so no request leaks out while reset is held.
  always_comb begin
    imem_req = rst_n && (state_q == S_REQ);
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    pc4_d      = pc4_q;
    valid_d    = valid_q;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (branch_taken) begin
      pc_d       = word_align(branch_target);
      instr_d    = NOP_INSTR;
      valid_d    = 1'b0;
      skid_clear = 1'b1;
    end else if (state_q == S_HOLD) begin
      if (!stall) begin
        instr_d    = skid_data;
        pc4_d      = skid_pc4;
        valid_d    = skid_valid;
        skid_clear = 1'b1;
      end
    end else if (accept) begin
      pc_d = pc_plus4;
      if (stall) begin
        skid_load = 1'b1;
      end else begin
        instr_d = imem_rdata;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end else if (!stall) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  fetch_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (imem_rdata),
    .pc4_i   (pc_plus4),
    .data_o  (skid_data),
    .pc4_o   (skid_pc4),
    .valid_o (skid_valid)
  );

  assign imem_addr   = word_align(pc_q);
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign opcode      = instr_q[31:26];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed scenarios then random traffic, checked against a queue-based fetch model.
module tb_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, stall, branch_taken, imem_ack;
  logic [31:0] branch_target, imem_rdata;

  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_instr, if_id_pc4;
  logic [5:0]  opcode;

  logic        w_imem_req, w_if_id_valid;
  logic [31:0] w_imem_addr, w_if_id_instr, w_if_id_pc4;
  logic [5:0]  w_opcode;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .opcode(opcode)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_id_instr(w_if_id_instr),
    .if_id_pc4(w_if_id_pc4), .if_id_valid(w_if_id_valid), .opcode(w_opcode)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: fetch pointer, decode-side register and a queue of parked words.
  logic        m_known = 1'b0;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [63:0] m_park[$];

  logic        rand_mode = 1'b0;
  logic        src_w = 1'b0;
  logic [31:0] mem_xor = 32'h0;
  logic [5:0]  op_tab [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] v;
    v = a ^ mem_xor;
    if (rand_mode) return {op_tab[$urandom_range(0, 5)], v[25:0]};
    return a;
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      m_known = 1'b1;
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_park.delete();
    end else if (branch_taken) begin
      m_pc = branch_target & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_valid = 1'b0;
      m_park.delete();
    end else if (m_park.size() > 0) begin
      if (!stall) begin
        {m_instr, m_pc4} = m_park.pop_front();
        m_valid = 1'b1;
      end
    end else if (imem_ack) begin
      if (stall) m_park.push_back({imem_rdata, m_pc + 32'd4});
      else begin
        m_instr = imem_rdata; m_pc4 = m_pc + 32'd4; m_valid = 1'b1;
      end
      m_pc = m_pc + 32'd4;
    end else if (!stall) begin
      m_instr = 32'h0; m_valid = 1'b0;
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t,
                     input logic a);
    @(negedge clk);
    rst_n = r; stall = s; branch_taken = b; branch_target = t; imem_ack = a;
    #1;
    imem_rdata = mem_word(src_w ? w_imem_addr : imem_addr);
    if (m_known) begin
      chk("req", {31'b0, imem_req}, {31'b0, rst_n && (m_park.size() == 0)});
      chk("addr", imem_addr, m_pc & 32'hFFFF_FFFC);
      chk("instr", if_id_instr, m_instr);
      chk("pc4", if_id_pc4, m_pc4);
      chk("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      chk("opcode", {26'b0, opcode}, {26'b0, m_instr[31:26]});
    end
    @(posedge clk);
    model_step();
  endtask

  initial begin
    logic r, s, b, a;
    op_tab[0] = OP_RTYPE; op_tab[1] = OP_SLTI; op_tab[2] = OP_LW;
    op_tab[3] = OP_SW;    op_tab[4] = OP_ADDI; op_tab[5] = OP_BEQ;
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;

    // Streaming fetch with ack every cycle.
    cyc(0, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0, 1);
    #1;
    chk("s1_instr", if_id_instr, 32'd12);
    chk("s1_pc4", if_id_pc4, 32'd16);
    chk("s1_addr", imem_addr, 32'd16);

    // Ack at pc=8 under a three-cycle stall.
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 1); cyc(1, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    #1;
    chk("s2_hold_instr", if_id_instr, 32'd4);
    chk("s2_hold_req", {31'b0, imem_req}, 32'd0);
    cyc(1, 1, 0, 0, 0); cyc(1, 1, 0, 0, 0);
    #1;
    chk("s2_still_4", if_id_instr, 32'd4);
    cyc(1, 0, 0, 0, 0);
    #1;
    chk("s2_deliver8", if_id_instr, 32'd8);
    chk("s2_pc4", if_id_pc4, 32'd12);
    chk("s2_next_addr", imem_addr, 32'd12);

    // Branch coinciding with an ack.
    cyc(1, 0, 0, 0, 1);
    cyc(1, 0, 1, 32'h0000_0103, 1);
    #1;
    chk("s3_valid", {31'b0, if_id_valid}, 32'd0);
    chk("s3_instr", if_id_instr, 32'd0);
    chk("s3_addr", imem_addr, 32'h0000_0100);
    cyc(1, 0, 0, 0, 1);
    #1;
    chk("s3_target_word", if_id_instr, 32'h0000_0100);

    // Branch while a word is parked.
    cyc(1, 1, 0, 0, 1);
    cyc(1, 1, 1, 32'h0000_0200, 0);
    #1;
    chk("s4_valid", {31'b0, if_id_valid}, 32'd0);
    chk("s4_addr", imem_addr, 32'h0000_0200);
    chk("s4_req", {31'b0, imem_req}, 32'd1);
    cyc(1, 0, 0, 0, 1);
    #1;
    chk("s4_no_stale", if_id_instr, 32'h0000_0200);

    // Reset mid-stall with a parked word.
    cyc(1, 1, 0, 0, 1); cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    #1;
    chk("s6_req", {31'b0, imem_req}, 32'd0);
    chk("s6_instr", if_id_instr, 32'd0);
    chk("s6_pc4", if_id_pc4, 32'd0);
    chk("s6_valid", {31'b0, if_id_valid}, 32'd0);
    chk("s6_addr", imem_addr, 32'd0);
    cyc(1, 0, 0, 0, 1);
    #1;
    chk("s6_restart_pc4", if_id_pc4, 32'd4);
    chk("s6_restart_valid", {31'b0, if_id_valid}, 32'd1);

    // Address wrap on the instance reset to FFFF_FFFC.
    src_w = 1'b1;
    cyc(0, 0, 0, 0, 0);
    #1;
    chk("w_reset_addr", w_imem_addr, 32'hFFFF_FFFC);
    chk("w_reset_req", {31'b0, w_imem_req}, 32'd0);
    cyc(1, 0, 0, 0, 1);
    #1;
    chk("w_instr1", w_if_id_instr, 32'hFFFF_FFFC);
    chk("w_pc4_1", w_if_id_pc4, 32'h0000_0000);
    chk("w_addr1", w_imem_addr, 32'h0000_0000);
    chk("w_req1", {31'b0, w_imem_req}, 32'd1);
    cyc(1, 0, 0, 0, 1);
    #1;
    chk("w_instr2", w_if_id_instr, 32'h0000_0000);
    chk("w_pc4_2", w_if_id_pc4, 32'h0000_0004);
    src_w = 1'b0;

    // Random traffic.
    rand_mode = 1'b1;
    mem_xor = $urandom;
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) >= 2);
      s = ($urandom_range(0, 99) < 30);
      b = ($urandom_range(0, 99) < 6);
      a = ($urandom_range(0, 99) < 65);
      cyc(r, s, b, $urandom, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have these ports, listed as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- stall  in  1  decode stage cannot accept a new instruction this cycle.
- branch_taken  in  1  one-cycle redirect pulse from the execute stage.
- branch_target  in  32  redirect address; valid when branch_taken=1.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  word address of the current request.
- imem_ack  in  1  memory returns imem_rdata this cycle for the outstanding request.
- imem_rdata  in  32  fetched instruction word.
- if_id_instr  out  32  registered instruction to decode.
- if_id_pc4  out  32  registered PC+4 of if_id_instr.
- if_id_valid  out  1  if_id_instr is a real instruction, not a bubble.
- opcode  out  6  if_id_instr[31:26]; drives the control unit.
REQ-002 SHALL have one parameter: RESET_PC, default 32'h0000_0000, the first fetch address.
REQ-003 SHALL use one clock, with a synchronous, active-low reset.

Function
REQ-004 SHALL hold a 32-bit pc register; imem_addr = pc with bits [1:0] forced to 0.
REQ-005 SHALL compute pc+4 modulo 2^32, so 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-006 SHALL implement a two-state FSM, S_REQ and S_HOLD.
- S_REQ: imem_req=1.
- S_HOLD: imem_req=0.
REQ-007 In S_REQ with imem_ack=1 and stall=0, SHALL load:
- if_id_instr<=imem_rdata.
- if_id_pc4<=pc+4.
- if_id_valid<=1.
- pc<=pc+4.
- Remain in S_REQ.
REQ-008 In S_REQ with imem_ack=1 and stall=1, SHALL:
- Capture imem_rdata and pc+4 into a one-entry skid buffer.
- Advance pc<=pc+4.
- Hold the IF/ID register.
- Go to S_HOLD.
REQ-009 In S_REQ with imem_ack=0, SHALL:
- Hold pc and keep imem_addr stable.
- If stall=1, hold IF/ID.
- If stall=0, insert a bubble: if_id_valid<=0, if_id_instr<=32'h0000_0000 (NOP).
REQ-010 In S_HOLD with stall=0, SHALL move the skid buffer into IF/ID with if_id_valid<=1 and return to S_REQ; with stall=1, SHALL hold everything.
REQ-011 branch_taken=1 SHALL take priority over stall and imem_ack in every state:
- pc<=branch_target with bits [1:0] cleared.
- if_id_valid<=0, if_id_instr<=0.
- Skid buffer invalidated.
- Next state S_REQ.
REQ-012 When imem_ack and branch_taken coincide, the returned word SHALL be discarded and never reach IF/ID.
REQ-013 imem_addr SHALL change while imem_req=1 only after an ack or on a branch redirect.
REQ-014 opcode SHALL be combinational from if_id_instr, zero-latency; fetch-to-decode latency SHALL be 1 cycle after ack when not stalled.
REQ-015 The stage SHALL never have more than one memory request outstanding, and SHALL never hold more than two instructions (IF/ID plus skid).

Reset
REQ-016 With rst_n=0 at a rising clk edge, SHALL set:
- pc<=RESET_PC.
- state<=S_REQ.
- if_id_instr<=0, if_id_pc4<=0, if_id_valid<=0.
- Skid buffer empty.
REQ-017 imem_req SHALL be 0 during any cycle in which rst_n=0, and SHALL be asserted in the first cycle after release.
REQ-018 Reset SHALL override branch_taken, stall and imem_ack; a response acked during reset SHALL be dropped.

Structure
REQ-019 Shared package cpu_pkg SHALL hold:
- RESET_PC default.
- NOP_INSTR = 32'h0.
- Opcode constants: OP_RTYPE 6'b000000, OP_SLTI 6'b000001, OP_LW 6'b000100, OP_SW 6'b000101, OP_ADDI 6'b000111, OP_BEQ 6'b000110.
- Fetch FSM state encoding.
REQ-020 The skid buffer (data, pc4, valid) SHALL be a sub-module named fetch_skid; the pc register and FSM stay in fetch_stage.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- Reset release, memory acks every cycle with rdata=addr -> imem_addr 0,4,8,12; if_id_instr tracks one cycle later; if_id_valid=1 from cycle 2.
- Ack at pc=8 with stall=1 for 3 cycles -> IF/ID holds word 4; the word at address 8 is delivered the cycle after stall falls; no word lost or duplicated.
- branch_taken=1, branch_target=32'h0000_0103, coinciding with an ack -> acked word dropped; if_id_valid=0 next cycle; next imem_addr=32'h0000_0100.
- Branch while in S_HOLD -> skid contents discarded; fetch restarts at the target; no stale instruction reaches IF/ID.
- RESET_PC=32'hFFFF_FFFC, two acks -> addresses FFFF_FFFC then 0000_0000; if_id_pc4=0 for the first instruction.
- rst_n=0 mid-stall with skid full -> all outputs zero and imem_req=0 next cycle; fetch restarts at RESET_PC.
